// File: rtl/enc_issue_ctrl.sv
// Issue controller for a fixed-latency vector_encoder: credit-gated issue, result FIFO, job FSM.
// Optional statistics counters are compiled in when ENC_ISSUE_STATS_EN is defined.
module enc_issue_ctrl #(
    parameter int LAT   = 3,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_last,
    output logic [127:0] enc_operand_a,
    input  logic [63:0]  enc_bit_enable,
    input  logic [127:0] enc_pp_select,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_bit_enable,
    output logic [127:0] out_pp_select,
    output logic         out_last,
    output logic         busy,
    output logic         done
`ifdef ENC_ISSUE_STATS_EN
    ,
    output logic [31:0]  stat_vec_cnt,
    output logic [31:0]  stat_zero_lane_cnt
`endif
);

    // state | meaning
    // IDLE  | no job active, issue allowed
    // RUN   | job in progress, last vector not yet issued
    // DRAIN | last vector issued, waiting for it to leave the FIFO
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = PW + 1;
    localparam int CW   = $clog2(DEPTH + LAT + 1) + 1;

    state_t            state_q, state_d;
    logic [LAT-1:0]    vld_q, vld_d;
    logic [LAT-1:0]    lst_q, lst_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic [63:0]       fifo_be_q [DEPTH];
    logic [127:0]      fifo_ps_q [DEPTH];
    logic [DEPTH-1:0]  fifo_last_q;

    logic              issue;
    logic              push;
    logic              pop;
    logic [CW-1:0]     in_flight;
    logic [CW-1:0]     occupancy;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < LAT; i++) begin
            in_flight = in_flight + CW'(vld_q[i]);
        end
    end

    // A pop this cycle frees its credit immediately, so a full pipe can pop and issue together.
    always_comb begin
        out_valid     = (count_q != '0);
        pop           = out_valid && out_ready;
        push          = vld_q[LAT-1];
        occupancy     = in_flight + CW'(count_q) - CW'(pop);
        in_ready      = rst_n && (state_q != DRAIN) && (occupancy < CW'(DEPTH));
        issue         = in_valid && in_ready;
        enc_operand_a = issue ? in_data : '0;
    end

    always_comb begin
        vld_d    = (vld_q << 1) | LAT'(issue);
        lst_d    = (lst_q << 1) | LAT'(issue && in_last);
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CNTW'(push) - CNTW'(pop);
    end

    assign out_bit_enable = fifo_be_q[rd_ptr_q];
    assign out_pp_select  = fifo_ps_q[rd_ptr_q];
    assign out_last       = out_valid && fifo_last_q[rd_ptr_q];
    assign busy           = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = in_last ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (issue && in_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            vld_q    <= '0;
            lst_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            vld_q    <= vld_d;
            lst_q    <= lst_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: count_q gates everything that reads it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_be_q[wr_ptr_q]   <= enc_bit_enable;
            fifo_ps_q[wr_ptr_q]   <= enc_pp_select;
            fifo_last_q[wr_ptr_q] <= lst_q[LAT-1];
        end
    end

`ifdef ENC_ISSUE_STATS_EN
    logic [31:0] stat_vec_q, stat_vec_d;
    logic [31:0] stat_zero_q, stat_zero_d;
    logic [4:0]  zero_lanes;
    logic [32:0] zero_sum;

    always_comb begin
        zero_lanes = '0;
        for (int i = 0; i < 16; i++) begin
            zero_lanes = zero_lanes + 5'(out_bit_enable[4*i +: 4] == 4'd0);
        end
        zero_sum    = {1'b0, stat_zero_q} + 33'(zero_lanes);
        stat_vec_d  = stat_vec_q;
        stat_zero_d = stat_zero_q;
        if (pop) begin
            if (stat_vec_q != '1) begin
                stat_vec_d = stat_vec_q + 32'd1;
            end
            stat_zero_d = zero_sum[32] ? '1 : zero_sum[31:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_vec_q  <= '0;
            stat_zero_q <= '0;
        end else begin
            stat_vec_q  <= stat_vec_d;
            stat_zero_q <= stat_zero_d;
        end
    end

    assign stat_vec_cnt       = stat_vec_q;
    assign stat_zero_lane_cnt = stat_zero_q;
`endif

endmodule

// File: tb/tb_enc_issue_ctrl.sv
// Bench for enc_issue_ctrl: radix-4 Booth encoder model with LAT delay, scoreboard monitor,
// directed scenarios followed by randomized jobs.
module tb_enc_issue_ctrl;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_last;
    logic [127:0] enc_operand_a;
    logic [63:0]  enc_bit_enable;
    logic [127:0] enc_pp_select;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_bit_enable;
    logic [127:0] out_pp_select;
    logic         out_last;
    logic         busy;
    logic         done;
`ifdef ENC_ISSUE_STATS_EN
    logic [31:0]  stat_vec_cnt;
    logic [31:0]  stat_zero_lane_cnt;
    logic [31:0]  exp_vec;
    logic [31:0]  exp_zero;
`endif

    int tests = 0;
    int fails = 0;
    int npop  = 0;
    int cyc_n = 0;
    bit rand_or = 0;

    enc_issue_ctrl #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .enc_operand_a(enc_operand_a), .enc_bit_enable(enc_bit_enable), .enc_pp_select(enc_pp_select),
        .out_valid(out_valid), .out_ready(out_ready), .out_bit_enable(out_bit_enable),
        .out_pp_select(out_pp_select), .out_last(out_last),
        .busy(busy), .done(done)
`ifdef ENC_ISSUE_STATS_EN
        , .stat_vec_cnt(stat_vec_cnt), .stat_zero_lane_cnt(stat_zero_lane_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Radix-4 Booth digits per lane: enable = digit nonzero, select = {negative, magnitude two}.
    function automatic logic [191:0] enc_vec(input logic [127:0] a);
        logic [63:0]  be;
        logic [127:0] ps;
        logic [8:0]   w;
        int           d;
        be = '0;
        ps = '0;
        for (int l = 0; l < 16; l++) begin
            w = {a[8*l +: 8], 1'b0};
            for (int k = 0; k < 4; k++) begin
                d = -2 * int'(w[2*k+2]) + int'(w[2*k+1]) + int'(w[2*k]);
                be[4*l+k]     = (d != 0);
                ps[8*l+2*k]   = (d == 2 || d == -2);
                ps[8*l+2*k+1] = (d < 0);
            end
        end
        return {ps, be};
    endfunction

    logic [127:0] enc_pipe [LAT];
    always @(posedge clk) begin
        enc_pipe[0] <= enc_operand_a;
        for (int i = 1; i < LAT; i++) enc_pipe[i] <= enc_pipe[i-1];
    end
    assign {enc_pp_select, enc_bit_enable} = enc_vec(enc_pipe[LAT-1]);

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [63:0]  be;
        logic [127:0] ps;
        logic         last;
        int           cyc;
    } exp_t;
    exp_t sbq[$];
    int   occ    = 0;
    bit   drain  = 0;
    bit   active = 0;

    // Reference: results leave in issue order exactly LAT+1 cycles after issue unless blocked.
    always @(negedge clk) begin : mon
        logic exp_ov, exp_pop, exp_ir, iss;
        exp_t e;
        int   zl;
        if (!rst_n) begin
            sbq.delete();
            occ = 0; drain = 0; active = 0;
`ifdef ENC_ISSUE_STATS_EN
            exp_vec = 0; exp_zero = 0;
`endif
        end else begin
            exp_ov  = (sbq.size() > 0) && (sbq[0].cyc + LAT + 1 <= cyc_n);
            exp_pop = exp_ov && out_ready;
            exp_ir  = !drain && ((occ - int'(exp_pop)) < DEPTH);
            iss     = in_valid && exp_ir;
            chk("out_valid", out_valid, exp_ov);
            chk("in_ready", in_ready, exp_ir);
            chk("enc_operand_a", enc_operand_a, iss ? in_data : 128'd0);
            chk("busy", busy, active);
            chk("done", done, exp_pop && sbq[0].last);
            if (exp_ov) begin
                chk("out_bit_enable", out_bit_enable, sbq[0].be);
                chk("out_pp_select", out_pp_select, sbq[0].ps);
                chk("out_last", out_last, sbq[0].last);
            end
`ifdef ENC_ISSUE_STATS_EN
            chk("stat_vec_cnt", stat_vec_cnt, exp_vec);
            chk("stat_zero_lane_cnt", stat_zero_lane_cnt, exp_zero);
`endif
            if (exp_pop) begin
`ifdef ENC_ISSUE_STATS_EN
                zl = 0;
                for (int l = 0; l < 16; l++) if (sbq[0].be[4*l +: 4] == 4'd0) zl++;
                exp_vec  = exp_vec + 1;
                exp_zero = exp_zero + zl;
`endif
                if (sbq[0].last) begin
                    drain  = 0;
                    active = 0;
                end
                void'(sbq.pop_front());
                occ--;
                npop++;
            end
            if (iss) begin
                {e.ps, e.be} = enc_vec(in_data);
                e.last = in_last;
                e.cyc  = cyc_n;
                sbq.push_back(e);
                occ++;
                active = 1;
                if (in_last) drain = 1;
            end
            cyc_n++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (rand_or) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_vec(input logic [127:0] d, input logic l);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            cyc();
            @(negedge clk);
            n++;
        end
        chk("send_accept", in_ready, 1'b1);
        cyc();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < bound) begin
            cyc();
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1'b1);
        cyc();
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        int           np0;
        int           n;
        int           nv;
        logic [127:0] d5;
`ifdef ENC_ISSUE_STATS_EN
        logic [31:0]  z0;
`endif
        rst_n = 1'b0; in_valid = 1'b1; in_data = rnd128(); in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_enc_operand_a", enc_operand_a, 128'd0);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1'b1);
        cyc();

        // single-vector job
        out_ready = 1'b1;
        send_vec(rnd128(), 1'b1);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        chk("issue_to_out_latency", lat, 4);
        chk("single_out_last", out_last, 1'b1);
        chk("single_done", done, 1'b1);
        chk("single_busy_hi", busy, 1'b1);
        cyc();
        @(negedge clk);
        chk("single_busy_lo", busy, 1'b0);
        chk("single_done_lo", done, 1'b0);
        cyc();

        // ten vectors against a blocked output
        out_ready = 1'b0;
        np0 = npop;
        for (int i = 0; i < 4; i++) send_vec(rnd128(), 1'b0);
        d5 = rnd128();
        in_valid = 1'b1; in_data = d5; in_last = 1'b0;
        @(negedge clk);
        chk("stall_ready_drop", in_ready, 1'b0);
        repeat (8) begin
            cyc();
            @(negedge clk);
            chk("stall_ready_held", in_ready, 1'b0);
        end
        chk("stall_out_valid", out_valid, 1'b1);
        chk("stall_no_pops", npop - np0, 0);
        cyc();
        out_ready = 1'b1;
        send_vec(d5, 1'b0);
        for (int i = 5; i < 10; i++) send_vec(rnd128(), i == 9);
        wait_done(100);
        chk("stall_pop_total", npop - np0, 10);
        chk("stall_sb_empty", sbq.size(), 0);

        // single nonzero lane
        out_ready = 1'b1;
        send_vec(128'h80, 1'b1);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            cyc();
            @(negedge clk);
            n++;
        end
        chk("lane0_be", out_bit_enable, 64'h8);
        chk("lane0_ps", out_pp_select, 128'hC0);
        chk("lane0_done", done, 1'b1);
`ifdef ENC_ISSUE_STATS_EN
        z0 = stat_zero_lane_cnt;
`endif
        cyc();
`ifdef ENC_ISSUE_STATS_EN
        @(negedge clk);
        chk("lane0_zero_stat", stat_zero_lane_cnt, z0 + 32'd15);
        cyc();
`endif

        // full FIFO: pop and issue in the same cycle
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_vec(rnd128(), 1'b0);
        repeat (LAT + 1) cyc();
        @(negedge clk);
        chk("full_ready_lo", in_ready, 1'b0);
        chk("full_out_valid", out_valid, 1'b1);
        cyc();
        out_ready = 1'b1; in_valid = 1'b1; in_data = rnd128(); in_last = 1'b0;
        @(negedge clk);
        chk("full_pop_issue_ready", in_ready, 1'b1);
        chk("full_pop_issue_ov", out_valid, 1'b1);
        cyc();
        out_ready = 1'b0; in_valid = 1'b0;
        repeat (LAT + 1) cyc();
        @(negedge clk);
        chk("full_occ_restored", in_ready, 1'b0);
        chk("full_ov_after", out_valid, 1'b1);
        cyc();
        out_ready = 1'b1;
        send_vec(rnd128(), 1'b1);
        wait_done(100);

        // reset with three vectors in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_vec(rnd128(), 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 1'b0);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        repeat (2) cyc();
        @(negedge clk);
        #2 rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_release_ready", in_ready, 1'b1);
        chk("midrst_release_busy", busy, 1'b0);
        repeat (6) begin
            cyc();
            @(negedge clk);
            chk("midrst_no_out_valid", out_valid, 1'b0);
        end
        cyc();

        // in_valid held through DRAIN
        out_ready = 1'b1;
        send_vec(rnd128(), 1'b1);
        in_valid = 1'b1; in_data = rnd128(); in_last = 1'b1;
        n = 0;
        @(negedge clk);
        while (!done && n < 50) begin
            chk("drain_ready_lo", in_ready, 1'b0);
            cyc();
            @(negedge clk);
            n++;
        end
        chk("drain_done_seen", done, 1'b1);
        chk("drain_ready_at_done", in_ready, 1'b0);
        cyc();
        @(negedge clk);
        chk("drain_ready_after_done", in_ready, 1'b1);
        cyc();
        in_valid = 1'b0; in_last = 1'b0;
        wait_done(50);

        // randomized jobs with random output back-pressure
        rand_or = 1;
        for (int j = 0; j < 8; j++) begin
            nv = $urandom_range(1, 6);
            for (int v = 0; v < nv; v++) begin
                if ($urandom_range(0, 3) == 0) cyc();
                send_vec(rnd128(), v == nv - 1);
            end
            wait_done(400);
        end
        rand_or = 0;
        out_ready = 1'b1;
        repeat (4) cyc();
        chk("final_sb_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/enc_issue_ctrl.md
ENC_ISSUE_CTRL -- requirements
Module: enc_issue_ctrl

Interface
REQ-001 SHALL have parameter LAT, default 3, meaning vector_encoder operand-to-output latency in cycles.
REQ-002 SHALL have parameter DEPTH, default 4, meaning result FIFO entries (power of two, >=2).
REQ-003 SHALL have ports: clk  in  1  clock; rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: in_valid  in  1; in_ready  out  1; in_data  in  128  16 signed 8-bit operands; in_last  in  1  final vector of a job.
REQ-005 SHALL have ports: enc_operand_a  out  128  to encoder; enc_bit_enable  in  64  16x4 flattened, lane i at [4i+3:4i]; enc_pp_select  in  128  16x8 flattened, lane i at [8i+7:8i].
REQ-006 SHALL have ports: out_valid  out  1; out_ready  in  1; out_bit_enable  out  64; out_pp_select  out  128; out_last  out  1.
REQ-007 SHALL have ports: busy  out  1  state!=IDLE; done  out  1  one-cycle pulse at job end.

Function
REQ-008 SHALL issue a vector (in_valid&&in_ready) by driving in_data on enc_operand_a that cycle; enc_operand_a SHALL be 0 on non-issue cycles.
REQ-009 SHALL track in-flight vectors with a LAT-stage valid/last shift register; the stage-LAT entry marks enc_bit_enable/enc_pp_select valid in that cycle.
REQ-010 SHALL write each stage-LAT result {bit_enable, pp_select, last} into the FIFO the same cycle; the encoder never stalls, so no result is dropped.
REQ-011 SHALL assert in_ready only when in_flight + fifo_count < DEPTH and state is IDLE or RUN (credit rule; in_ready independent of in_valid).
REQ-012 SHALL count a FIFO pop in the same cycle as credit release, so full-occupancy pop+issue is allowed.
REQ-013 SHALL present FIFO head on out_*; out_valid=!empty; pop on out_valid&&out_ready; payload stable while out_valid&&!out_ready.
REQ-014 SHALL support simultaneous FIFO push and pop, including when full-with-pop and empty-with-push (no bypass: push to empty FIFO appears on out_valid next cycle).
REQ-015 SHALL wrap FIFO read/write pointers modulo DEPTH.
REQ-016 SHALL implement states IDLE, RUN, DRAIN: IDLE->RUN on first issue; RUN->DRAIN on issue with in_last=1; DRAIN->IDLE on pop with out_last=1, pulsing done that cycle.
REQ-017 SHALL deassert in_ready throughout DRAIN.
REQ-018 SHALL, on an issue with in_last=1 from IDLE, go directly to DRAIN.
REQ-019 SHALL give a minimum issue-to-out_valid latency of LAT+1 cycles.

Reset
REQ-020 SHALL, on rst_n low, asynchronously clear state to IDLE, valid shift register, FIFO pointers/count, and stats counters.
REQ-021 SHALL reset outputs to: in_ready=0 during reset then 1 first cycle after release, out_valid=0, out_last=0, busy=0, done=0, enc_operand_a=0.
REQ-022 SHALL discard all in-flight and buffered results on reset mid-job; the encoder's stale outputs after reset SHALL NOT be captured (valid shift register is cleared).

Configuration
REQ-023 SHALL, when ENC_ISSUE_STATS_EN is defined, add outputs stat_vec_cnt (32, pops) and stat_zero_lane_cnt (32, popped lanes with bit_enable==0), both saturating at all-ones.
REQ-024 SHALL, without ENC_ISSUE_STATS_EN, omit those ports and counters entirely.

Verification
REQ-025 SHALL cover: single vector, in_last=1, out_ready=1 -> out_valid at cycle 4 after issue, out_last=1, done pulse, busy 1->0.
REQ-026 SHALL cover: 10 back-to-back vectors, out_ready=0 -> in_ready drops after 4 issues, exactly 4 results buffered, none lost; release out_ready -> all 10 out in order.
REQ-027 SHALL cover: operand 0x80 in lane 0, rest 0 -> lane 0 result matches encoder model, lanes 1-15 bit_enable=0 (stat_zero_lane_cnt +=15 with macro).
REQ-028 SHALL cover: FIFO full, out_ready=1 and in_valid=1 same cycle -> one pop and one issue same cycle, occupancy unchanged after LAT.
REQ-029 SHALL cover: rst_n asserted with 3 vectors in flight -> no out_valid after release, in_ready=1 next cycle, state IDLE.
REQ-030 SHALL cover: in_valid held during DRAIN -> in_ready=0 until done, next job accepted the cycle after done.
